// File: rtl/axis_fifo.sv
// axis_fifo: single-clock AXI-Stream first-word-fall-through buffer.
// s_tready is derived from registered occupancy only.
module axis_fifo #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  output logic              s_tready,
  output logic              m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  input  logic              m_tready,
  output logic [ADDR_W:0]   count,
  output logic              almost_full
);

  localparam logic [ADDR_W:0] FULL_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C =
    (ADDR_W+1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              push, pop;

  assign s_tready    = !rst && (cnt_q != FULL_C);
  assign m_tvalid    = (cnt_q != '0);
  assign m_tdata     = m_tvalid ? mem_q[rd_q] : '0;
  assign count       = cnt_q;
  assign almost_full = (cnt_q >= AF_C);
  assign push        = s_tvalid && s_tready;
  assign pop         = m_tvalid && m_tready;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      unique case (1'b1)
        push && !pop: cnt_d = cnt_q + 1'b1;
        pop && !push: cnt_d = cnt_q - 1'b1;
        default:      cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is never cleared; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= s_tdata;
  end

endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: randomized and directed checks of axis_fifo
// against a queue-based reference model.
module tb_axis_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          s_tvalid, s_tready;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid, m_tready;
  logic [DW-1:0] m_tdata;
  logic [3:0]    count;
  logic          almost_full;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];

  always #5 clk = ~clk;

  axis_fifo #(
    .DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata),
    .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata),
    .m_tready(m_tready),
    .count(count), .almost_full(almost_full)
  );

  // Reference: a queue bounded at DEPTH, cleared by rst/flush.
  always @(posedge clk) begin
    bit mpush, mpop;
    mpush = !rst && s_tvalid && (q.size() < DEPTH);
    mpop  = m_tready && (q.size() > 0);
    if (rst || flush) q.delete();
    else begin
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(s_tdata);
    end
  end

  function automatic logic [DW-1:0] exp_head();
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  task automatic idle_inputs();
    flush = 0; s_tvalid = 0;
    s_tdata = '0; m_tready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got %b want 0", s_tready);
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0 ||
        m_tdata !== 16'h0000 || count !== 4'd0 ||
        almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got r%b v%b d%h c%0d af%b want r1 v0 d0000 c0 af0",
               s_tready, m_tvalid, m_tdata, count, almost_full);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    s_tvalid = 1; s_tdata = 16'h1111; m_tready = 0;
    @(negedge clk);
    s_tvalid = 0;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'h1111 ||
        count !== 4'd1) begin
      errors++;
      $display("FAIL single_push got v%b d%h c%0d want v1 d1111 c1",
               m_tvalid, m_tdata, count);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 16'h1111) begin
        errors++;
        $display("FAIL single_hold got v%b d%h want v1 d1111",
                 m_tvalid, m_tdata);
      end
    end
    m_tready = 1;
    @(negedge clk);
    m_tready = 0;
    checks++;
    if (m_tvalid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL single_pop got v%b c%0d want v0 c0",
               m_tvalid, count);
    end
  endtask

  task automatic test_full();
    m_tready = 0;
    for (int i = 1; i <= 8; i++) begin
      s_tvalid = 1; s_tdata = DW'(i);
      @(negedge clk);
      checks++;
      if (count !== 4'(i) || almost_full !== (i >= AF)) begin
        errors++;
        $display("FAIL fill_%0d got c%0d af%b want c%0d af%b",
                 i, count, almost_full, i, (i >= AF));
      end
    end
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b want 0", s_tready);
    end
    s_tdata = 16'h0009;
    repeat (3) @(negedge clk);
    checks++;
    if (count !== 4'd8 || m_tdata !== 16'h0001) begin
      errors++;
      $display("FAIL full_hold got c%0d d%h want c8 d0001",
               count, m_tdata);
    end
    m_tready = 1;
    @(negedge clk);
    m_tready = 0;
    checks++;
    if (count !== 4'd7 || s_tready !== 1'b1 ||
        m_tdata !== 16'h0002) begin
      errors++;
      $display("FAIL full_pop got c%0d r%b d%h want c7 r1 d0002",
               count, s_tready, m_tdata);
    end
    @(negedge clk);
    s_tvalid = 0;
    checks++;
    if (count !== 4'd8) begin
      errors++;
      $display("FAIL full_ninth got c%0d want c8", count);
    end
    m_tready = 1;
    for (int k = 2; k <= 9; k++) begin
      checks++;
      if (m_tdata !== DW'(k) || m_tvalid !== 1'b1) begin
        errors++;
        $display("FAIL drain_%0d got v%b d%h want v1 d%h",
                 k, m_tvalid, m_tdata, DW'(k));
      end
      @(negedge clk);
    end
    m_tready = 0;
    checks++;
    if (m_tvalid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL drain_empty got v%b c%0d want v0 c0",
               m_tvalid, count);
    end
  endtask

  task automatic test_back_to_back();
    int tx = 0, rx = 0;
    m_tready = 1;
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (count > 4'd1) begin
        errors++;
        $display("FAIL b2b_count got %0d want <=1", count);
      end
      if (m_tvalid) begin
        checks++;
        if (m_tdata !== DW'(16'h0100 + rx)) begin
          errors++;
          $display("FAIL b2b_order got %h want %h",
                   m_tdata, DW'(16'h0100 + rx));
        end
        rx++;
      end
      if (tx < 20) begin
        s_tvalid = 1; s_tdata = DW'(16'h0100 + tx);
        tx++;
      end else s_tvalid = 0;
      @(negedge clk);
    end
    m_tready = 0;
    checks++;
    if (rx != 20) begin
      errors++;
      $display("FAIL b2b_total got %0d want 20", rx);
    end
  endtask

  task automatic test_random();
    int pushes = 0, cyc = 0;
    int pin = 50, pout = 50;
    bit stall = 0;
    logic [DW-1:0] prev = '0;
    while (pushes < 600 && cyc < 20000) begin
      if (cyc % 150 == 0) begin
        pin  = $urandom_range(10, 90);
        pout = $urandom_range(10, 90);
      end
      checks++;
      if (m_tvalid !== (q.size() > 0) ||
          m_tdata !== exp_head() ||
          count !== 4'(q.size()) ||
          s_tready !== (q.size() < DEPTH) ||
          almost_full !== (q.size() >= AF)) begin
        errors++;
        $display("FAIL rand_cyc%0d got v%b d%h c%0d r%b af%b want n%0d d%h",
                 cyc, m_tvalid, m_tdata, count, s_tready,
                 almost_full, q.size(), exp_head());
      end
      checks++;
      if (count > 4'(DEPTH) || (s_tready && count == 4'd8)) begin
        errors++;
        $display("FAIL rand_bound got c%0d r%b want c<=8 no ready at 8",
                 count, s_tready);
      end
      if (stall) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev) begin
          errors++;
          $display("FAIL rand_stable got v%b d%h want v1 d%h",
                   m_tvalid, m_tdata, prev);
        end
      end
      s_tvalid = ($urandom_range(0, 99) < pin);
      s_tdata  = DW'($urandom);
      m_tready = ($urandom_range(0, 99) < pout);
      if (s_tvalid && s_tready) pushes++;
      stall = m_tvalid && !m_tready;
      prev  = m_tdata;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (pushes < 600) begin
      errors++;
      $display("FAIL rand_budget got %0d pushes want 600", pushes);
    end
    s_tvalid = 0;
    m_tready = 1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      checks++;
      if (m_tdata !== exp_head()) begin
        errors++;
        $display("FAIL rand_drain got %h want %h",
                 m_tdata, exp_head());
      end
      @(negedge clk);
    end
    m_tready = 0;
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base);
    m_tready = 0;
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1; s_tdata = base + DW'(i);
      @(negedge clk);
    end
    s_tvalid = 0;
  endtask

  task automatic check_beef(input string tag);
    s_tvalid = 1; s_tdata = 16'hBEEF;
    @(negedge clk);
    s_tvalid = 0;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'hBEEF ||
        count !== 4'd1) begin
      errors++;
      $display("FAIL %s_beef got v%b d%h c%0d want v1 dbeef c1",
               tag, m_tvalid, m_tdata, count);
    end
    m_tready = 1;
    @(negedge clk);
    m_tready = 0;
  endtask

  task automatic test_flush();
    fill(5, 16'h0A00);
    flush = 1; s_tvalid = 1; s_tdata = 16'hDEAD;
    @(negedge clk);
    flush = 0; s_tvalid = 0;
    checks++;
    if (count !== 4'd0 || m_tvalid !== 1'b0 ||
        m_tdata !== 16'h0000) begin
      errors++;
      $display("FAIL flush_clear got c%0d v%b d%h want c0 v0 d0000",
               count, m_tvalid, m_tdata);
    end
    check_beef("flush");
  endtask

  task automatic test_rst_clear();
    fill(5, 16'h0B00);
    rst = 1; s_tvalid = 1; s_tdata = 16'hDEAD;
    #1;
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ready got %b want 0", s_tready);
    end
    @(negedge clk);
    rst = 0; s_tvalid = 0;
    checks++;
    if (count !== 4'd0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear got c%0d v%b want c0 v0",
               count, m_tvalid);
    end
    check_beef("rst_mid");
    fill(8, 16'h0C00);
    checks++;
    if (count !== 4'd8) begin
      errors++;
      $display("FAIL rst_full_fill got c%0d want c8", count);
    end
    rst = 1; s_tvalid = 1; s_tdata = 16'hDEAD; m_tready = 1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b0 || count !== 4'd0) begin
        errors++;
        $display("FAIL rst_full got r%b c%0d want r0 c0",
                 s_tready, count);
      end
    end
    rst = 0; s_tvalid = 0; m_tready = 0;
    #1;
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_full_exit got r%b v%b want r1 v0",
               s_tready, m_tvalid);
    end
    @(negedge clk);
    check_beef("rst_full");
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_random();
    test_flush();
    test_rst_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_fifo.md
Name: axis_fifo

Overview:
- Synchronous AXI-Stream buffering FIFO placed between the stream master and the stream slave.
- Decouples producer and consumer back-pressure and absorbs bursts while the consumer stalls.
- Slave-side port accepts words from the master; master-side port presents them to the slave in first-word-fall-through order.
- Single clock domain; no data transformation.

Parameters:
- DATA_W, 16, width of the stream data in bits.
- DEPTH, 8, number of storage entries; must be a power of two and ≥ 2.
- AF_LEVEL, 6, occupancy at or above which almost_full asserts; range 1..DEPTH.
- ADDR_W, log2(DEPTH), derived pointer width; not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- flush  input  1  synchronous clear of all buffered words
- s_tvalid  input  1  upstream word valid
- s_tdata  input  DATA_W  upstream word
- s_tready  output  1  FIFO can accept a word
- m_tvalid  output  1  downstream word valid
- m_tdata  output  DATA_W  downstream word (head of FIFO)
- m_tready  input  1  downstream accepts word
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- almost_full  output  1  count ≥ AF_LEVEL

Behaviour:
Interface:
- One clock, clk.
- Reset rst is synchronous and active-high.
- All state changes occur on the rising edge of clk only.

Reset and flush:
- rst high at an edge: wr_ptr = 0, rd_ptr = 0, count = 0. Storage array is not cleared.
- While rst is high, s_tready = 0, so no word is accepted during reset.
- After reset, m_tvalid = 0, m_tdata = 0, count = 0, almost_full = 0, and s_tready = 1 from the first cycle with rst low.
- Priority: rst > flush > push/pop.
- flush high at an edge (rst low): pointers and count go to 0.
- A push or pop handshake in the same cycle as flush is discarded. The upstream word is lost; the bench must treat it as dropped.

Handshakes:
- push = s_tvalid && s_tready.
- pop = m_tvalid && m_tready.
- s_tready = !rst && (count != DEPTH). It depends on registered count only, never on m_tready, so there is no combinational ready path through the FIFO.
- m_tvalid = (count != 0).
- m_tdata = mem[rd_ptr] when m_tvalid is 1, else 0.
- m_tvalid and m_tdata stay stable while m_tvalid = 1 and m_tready = 0.

Push and pop:
- push: mem[wr_ptr] <= s_tdata; wr_ptr increments modulo DEPTH.
- pop: rd_ptr increments modulo DEPTH.
- count update:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged

Latency:
- A word pushed into an empty FIFO at edge N appears on m_tvalid/m_tdata in the cycle after edge N; it can be popped at edge N+1.
- There is no bypass path, so a zero-cycle pass-through is not allowed.

Boundary conditions:
- Full (count = DEPTH): s_tready = 0, so there is no push even if a pop happens in the same cycle. s_tready returns to 1 in the cycle after the first pop.
- Empty: m_tvalid = 0, and m_tready is ignored.
- Simultaneous push and pop at 0 < count < DEPTH: both occur and count is unchanged.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no gap or duplicate. Order is strictly FIFO.
- Overflow and underflow are impossible by construction. The bench asserts count ≤ DEPTH at all times.
- almost_full is combinational from registered count.
- rst or flush mid-burst: every buffered word is discarded, and the next popped word is the first one pushed after the clear.

Test Plan:
- Reset, then idle -> s_tready=1, m_tvalid=0, m_tdata=0x0000, count=0, almost_full=0.
- Push 0x1111 with m_tready=0 -> the next cycle shows m_tvalid=1, m_tdata=0x1111, count=1; hold 5 cycles -> m_tdata is stable. Raise m_tready -> popped; m_tvalid=0 the following cycle.
- Push 0x0001..0x0008 with m_tready=0 -> after the 8th push count=8, s_tready=0, almost_full=1 (from count=6). A 9th word 0x0009 is held on s_tdata and not accepted. Pop once -> s_tready=1 the next cycle, then 0x0009 is accepted.
- Continuous s_tvalid=1 and m_tready=1 for 20 words 0x0100..0x0113 -> output is in order with no loss or duplicate, count ≤ 1 throughout, and pointers wrap twice.
- Random s_tvalid and m_tready (≥ 500 words, scoreboard) -> exact in-order match; s_tready never high at count=8; m_tdata never changes while m_tvalid && !m_tready.
- Fill 5 words, assert flush together with a push of 0xDEAD -> count=0, m_tvalid=0. Push 0xBEEF -> the next pop yields 0xBEEF. Repeat with rst instead of flush, including a rst pulse during a full FIFO -> same result, and s_tready=0 during rst.
